// File: rtl/eth_pkg.sv
// Ethernet receive-path shared types and flag positions.
// Used by rx_word_packer and packet_receiver.
package eth_pkg;

  localparam int WORD_W     = 32;
  localparam int FLAGS_W    = 4;
  localparam int FLAG_SOF   = 0;
  localparam int FLAG_EOF   = 1;
  localparam int FLAG_VB_LO = 2;
  localparam int FLAG_VB_HI = 3;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [1:0]        vb;
    logic              eof;
    logic              sof;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  function automatic logic [FLAGS_W-1:0] entry_flags(
    input rx_entry_t e
  );
    logic [FLAGS_W-1:0] f;
    f = '0;
    f[FLAG_SOF] = e.sof;
    f[FLAG_EOF] = e.eof;
    f[FLAG_VB_HI:FLAG_VB_LO] = e.vb;
    return f;
  endfunction

endpackage

// File: rtl/rx_word_ram.sv
// Simple dual-port word store for the receive packer.
// One write port, one synchronous read port.
module rx_word_ram #(
  parameter int AW = 9,
  parameter int W  = 35
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_word_packer.sv
// Packs received frame bytes into 32-bit words with frame flags.
// Frames are committed whole; bad or short frames are rewound.
module rx_word_packer
  import eth_pkg::*;
#(
  parameter int AW        = 9,
  parameter int MIN_BYTES = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_dv_i,
  input  logic        rx_er_i,
  output logic [31:0] rd_data_o,
  output logic [3:0]  rd_flags_o,
  output logic        rd_src_rdy_o,
  input  logic        rd_dst_rdy_i,
  output logic [15:0] frames_dropped_o,
  output logic        overflow_o
);

  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [15:0] MIN_CNT = 16'(MIN_BYTES);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  wr_commit;
  logic [AW:0]  rd_ptr;
  logic         armed;
  logic         in_frame;
  logic         dropping;
  logic [15:0]  byte_cnt;
  logic [1:0]   lane;
  logic [31:0]  asm_word;
  logic [31:0]  hold_data;
  logic         hold_valid;
  logic         hold_sof;

  logic         full;
  logic         empty;
  logic         byte_ok;
  logic         frame_end;
  logic         we;
  logic         drop;
  logic         drop_full;
  rx_entry_t    wentry;

  logic         ram_vld;
  logic         ram_take;
  logic         rd_issue;
  logic [ENTRY_W-1:0] ram_q;
  rx_entry_t    rentry;

  assign lane  = byte_cnt[1:0];
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_commit == rd_ptr);

  assign byte_ok   = rx_dv_i && armed && !dropping;
  assign frame_end = !rx_dv_i && in_frame && !dropping;

  // A held word is flushed by the next byte, or with EOF at frame end.
  always_comb begin
    we        = 1'b0;
    drop      = 1'b0;
    drop_full = 1'b0;
    wentry    = '0;
    if (byte_ok) begin
      if (rx_er_i) begin
        drop = 1'b1;
      end else if (lane == 2'd0 && hold_valid) begin
        if (full) begin
          drop      = 1'b1;
          drop_full = 1'b1;
        end else begin
          we          = 1'b1;
          wentry.data = hold_data;
          wentry.sof  = hold_sof;
        end
      end
    end else if (frame_end) begin
      if (byte_cnt < MIN_CNT) begin
        drop = 1'b1;
      end else if (full) begin
        drop      = 1'b1;
        drop_full = 1'b1;
      end else if (lane == 2'd0) begin
        we          = 1'b1;
        wentry.data = hold_data;
        wentry.sof  = hold_sof;
        wentry.eof  = 1'b1;
      end else begin
        we          = 1'b1;
        wentry.data = asm_word;
        wentry.sof  = (byte_cnt < 16'd4);
        wentry.eof  = 1'b1;
        wentry.vb   = lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      wr_commit        <= '0;
      armed            <= 1'b0;
      in_frame         <= 1'b0;
      dropping         <= 1'b0;
      byte_cnt         <= '0;
      asm_word         <= '0;
      hold_data        <= '0;
      hold_valid       <= 1'b0;
      hold_sof         <= 1'b0;
      frames_dropped_o <= '0;
      overflow_o       <= 1'b0;
    end else begin
      overflow_o <= drop_full;
      if (drop) begin
        wr_ptr <= wr_commit;
        if (frames_dropped_o != 16'hFFFF)
          frames_dropped_o <= frames_dropped_o + 16'd1;
      end else if (we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (frame_end)
          wr_commit <= wr_ptr + PTR_ONE;
      end
      if (!rx_dv_i) begin
        armed      <= 1'b1;
        in_frame   <= 1'b0;
        dropping   <= 1'b0;
        byte_cnt   <= '0;
        hold_valid <= 1'b0;
      end else if (armed) begin
        in_frame <= 1'b1;
        if (drop) begin
          dropping <= 1'b1;
        end else if (!dropping) begin
          byte_cnt <= byte_cnt + 16'd1;
          unique case (lane)
            2'd0: begin
              asm_word   <= {rx_data_i, 24'h0};
              hold_valid <= 1'b0;
            end
            2'd1: asm_word[23:16] <= rx_data_i;
            2'd2: asm_word[15:8]  <= rx_data_i;
            2'd3: begin
              hold_data  <= {asm_word[31:8], rx_data_i};
              hold_valid <= 1'b1;
              hold_sof   <= (byte_cnt == 16'd3);
            end
          endcase
        end
      end
    end
  end

  rx_word_ram #(
    .AW (AW),
    .W  (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wentry),
    .re    (rd_issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  assign rentry   = ram_q;
  assign ram_take = ram_vld && (!rd_src_rdy_o || rd_dst_rdy_i);
  assign rd_issue = !empty && (!ram_vld || ram_take);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      ram_vld      <= 1'b0;
      rd_src_rdy_o <= 1'b0;
      rd_data_o    <= '0;
      rd_flags_o   <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        ram_vld <= 1'b1;
      end else if (ram_take) begin
        ram_vld <= 1'b0;
      end
      if (ram_take) begin
        rd_src_rdy_o <= 1'b1;
        rd_data_o    <= rentry.data;
        rd_flags_o   <= entry_flags(rentry);
      end else if (rd_dst_rdy_i) begin
        rd_src_rdy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed bench for rx_word_packer: vector table plus
// hand sequences for error, reset, overflow and backpressure.
module tb_rx_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [31:0] rd_data, rd_data2;
  logic [3:0]  rd_flags, rd_flags2;
  logic        src, src2;
  logic        dst = 1'b1;
  logic        dst2 = 1'b1;
  logic [15:0] drops, drops2;
  logic        ovf, ovf2;

  always #5 clk = ~clk;

  rx_word_packer #(.AW(9), .MIN_BYTES(14)) dut (
    .clk(clk), .reset(reset),
    .rx_data_i(rx_data), .rx_dv_i(rx_dv), .rx_er_i(rx_er),
    .rd_data_o(rd_data), .rd_flags_o(rd_flags),
    .rd_src_rdy_o(src), .rd_dst_rdy_i(dst),
    .frames_dropped_o(drops), .overflow_o(ovf)
  );

  rx_word_packer #(.AW(4), .MIN_BYTES(14)) dut2 (
    .clk(clk), .reset(reset),
    .rx_data_i(rx_data), .rx_dv_i(rx_dv), .rx_er_i(rx_er),
    .rd_data_o(rd_data2), .rd_flags_o(rd_flags2),
    .rd_src_rdy_o(src2), .rd_dst_rdy_i(dst2),
    .frames_dropped_o(drops2), .overflow_o(ovf2)
  );

  typedef struct {
    int          len;
    int          er_at;
    int          words;
    logic [35:0] first;
    logic [35:0] last;
    int          drop;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [35:0] out_q[$];
  logic [35:0] out2_q[$];
  logic [35:0] exp_q[$];
  int   stall_err = 0;
  int   ovf_cnt = 0;
  logic prev_stall = 1'b0;
  logic [35:0] prev_w = '0;
  logic rand_bp = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (src && dst)
        out_q.push_back({rd_data, rd_flags});
      if (src2 && dst2)
        out2_q.push_back({rd_data2, rd_flags2});
      if (prev_stall && (!src || {rd_data, rd_flags} != prev_w))
        stall_err <= stall_err + 1;
      prev_stall <= src && !dst;
      prev_w     <= {rd_data, rd_flags};
      if (ovf2)
        ovf_cnt <= ovf_cnt + 1;
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp)
      dst = 1'($urandom_range(0, 1));
  endtask

  task automatic push_model(input logic [7:0] b[$]);
    int n;
    int nw;
    logic [31:0] d;
    logic [3:0]  f;
    n  = b.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      f = '0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < n)
          d[31 - 8 * j -: 8] = b[4 * w + j];
      f[0] = (w == 0);
      f[1] = (w == nw - 1);
      if (w == nw - 1)
        f[3:2] = 2'(n % 4);
      exp_q.push_back({d, f});
    end
  endtask

  task automatic send(input logic [7:0] b[$], input int er_at);
    for (int k = 0; k < b.size(); k++) begin
      rx_dv   = 1'b1;
      rx_data = b[k];
      rx_er   = (k == er_at);
      tick();
    end
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    rx_data = '0;
    tick();
  endtask

  task automatic drain(input int want, input bit second);
    int t;
    t = 0;
    while (t < 3000 &&
           ((second ? out2_q.size() : out_q.size()) < want)) begin
      tick();
      t++;
    end
    repeat (10) tick();
  endtask

  task automatic cmp_q(input string name, input logic [35:0] got[$]);
    int bad;
    bad = 0;
    check({name, "_cnt"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i])
        bad++;
    check({name, "_data"}, bad, 0);
  endtask

  function automatic void ramp(output logic [7:0] b[$],
                               input int n, input int base);
    b = {};
    for (int k = 0; k < n; k++)
      b.push_back(8'(base + k));
  endfunction

  initial begin
    vec_t v[8];
    logic [7:0] b[$];
    logic [7:0] b2[$];
    int d0;
    int o0;
    int ln;

    v[0] = '{64, -1, 16, {32'h00010203, 4'h1},
             {32'h3C3D3E3F, 4'h2}, 0};
    v[1] = '{61, -1, 16, {32'h00010203, 4'h1},
             {32'h3C000000, 4'h6}, 0};
    v[2] = '{14, -1, 4, {32'h00010203, 4'h1},
             {32'h0C0D0000, 4'hA}, 0};
    v[3] = '{13, -1, 0, 36'h0, 36'h0, 1};
    v[4] = '{15, -1, 4, {32'h00010203, 4'h1},
             {32'h0C0D0E00, 4'hE}, 0};
    v[5] = '{16, -1, 4, {32'h00010203, 4'h1},
             {32'h0C0D0E0F, 4'h2}, 0};
    v[6] = '{100, 50, 0, 36'h0, 36'h0, 1};
    v[7] = '{17, -1, 5, {32'h00010203, 4'h1},
             {32'h10000000, 4'h6}, 0};

    repeat (3) tick();
    check("rst_src", src, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", rd_flags, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drops", drops, 0);
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      out_q.delete();
      ramp(b, v[i].len, 0);
      if (v[i].drop == 0)
        push_model(b);
      d0 = int'(drops);
      send(b, v[i].er_at);
      drain(v[i].words, 1'b0);
      check($sformatf("v%0d_words", i), out_q.size(), v[i].words);
      cmp_q($sformatf("v%0d_model", i), out_q);
      if (out_q.size() > 0) begin
        check($sformatf("v%0d_first", i), out_q[0], v[i].first);
        check($sformatf("v%0d_last", i),
              out_q[out_q.size() - 1], v[i].last);
      end
      check($sformatf("v%0d_drop", i), int'(drops) - d0, v[i].drop);
    end

    // error frame then good frame at zero IFG
    exp_q.delete();
    out_q.delete();
    ramp(b, 100, 0);
    ramp(b2, 60, 8'h80);
    push_model(b2);
    d0 = int'(drops);
    send(b, 50);
    send(b2, -1);
    drain(15, 1'b0);
    cmp_q("err_then_good", out_q);
    check("err_drop", int'(drops) - d0, 1);

    // reset in the middle of a frame
    exp_q.delete();
    out_q.delete();
    ramp(b, 64, 8'h40);
    for (int k = 0; k < 64; k++) begin
      rx_dv   = 1'b1;
      rx_data = b[k];
      reset   = (k == 30);
      tick();
      if (k == 30) begin
        check("mid_rst_src", src, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_flags", rd_flags, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_drops", drops, 0);
      end
    end
    rx_dv = 1'b0;
    tick();
    ramp(b, 64, 8'h10);
    push_model(b);
    send(b, -1);
    drain(16, 1'b0);
    cmp_q("after_rst", out_q);
    check("after_rst_drops", drops, 0);

    // overflow on the 16-word instance
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    dst2 = 1'b0;
    out2_q.delete();
    exp_q.delete();
    o0 = ovf_cnt;
    ramp(b, 64, 0);
    ramp(b2, 64, 8'h40);
    push_model(b);
    send(b, -1);
    send(b2, -1);
    repeat (5) tick();
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_drops", drops2, 1);
    check("ovf_stall_src", src2, 1);
    check("ovf_stall_word", {rd_data2, rd_flags2},
          {32'h00010203, 4'h1});
    dst2 = 1'b1;
    drain(16, 1'b1);
    cmp_q("ovf_out", out2_q);

    // random backpressure, back-to-back frames
    exp_q.delete();
    out_q.delete();
    d0 = int'(drops);
    rand_bp = 1'b1;
    for (int f = 0; f < 200; f++) begin
      ln = $urandom_range(14, 64);
      b = {};
      for (int k = 0; k < ln; k++)
        b.push_back(8'($urandom));
      push_model(b);
      send(b, -1);
    end
    drain(exp_q.size(), 1'b0);
    rand_bp = 1'b0;
    dst = 1'b1;
    repeat (5) tick();
    cmp_q("rand", out_q);
    check("rand_stall_stable", stall_err, 0);
    check("rand_drops", int'(drops) - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
